// File: rtl/clk_div_prog.sv
// ============================================================================
// Module   : clk_div_prog
// Brief    : Runtime-programmable integer clock divider (D = 2..2^DIV_W-1).
//            Divisor changes take effect only at the period wrap.
//            Optional macro CLK_DIV_ODD_DUTY50_EN gives 50% duty for odd D.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_div_prog #(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div_in,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick,
    output logic [DIV_W-1:0] div_cur,
    output logic             pending,
    output logic             div_err
);

    localparam logic [DIV_W-1:0] c_default = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] c_one     = DIV_W'(1);
    localparam logic [DIV_W-1:0] c_two     = DIV_W'(2);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_d_act;
    logic [DIV_W-1:0] r_shadow;
    logic             r_q_pos;
    logic             r_tick;
    logic             r_pending;
    logic             r_div_err;

    logic [DIV_W-1:0] w_last;
    logic [DIV_W-1:0] w_high;
    logic             w_wrap;
    logic             w_legal;

    assign w_last  = r_d_act - c_one;
    assign w_wrap  = en && (r_cnt == w_last);
    assign w_legal = (div_in >= c_two);

`ifdef CLK_DIV_ODD_DUTY50_EN
    // Odd D rounds the posedge high time down; the negedge flop adds the half cycle.
    assign w_high = r_d_act >> 1;
`else
    assign w_high = (r_d_act >> 1) + {{(DIV_W-1){1'b0}}, r_d_act[0]};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_q_pos   <= 1'b0;
            r_tick    <= 1'b0;
            r_d_act   <= c_default;
            r_shadow  <= c_default;
            r_pending <= 1'b0;
            r_div_err <= 1'b0;
        end else begin
            r_div_err <= div_load && !w_legal;

            if (en) begin
                r_cnt   <= w_wrap ? '0 : r_cnt + c_one;
                r_q_pos <= (r_cnt < w_high);
                r_tick  <= (r_cnt == '0);
            end else begin
                r_tick  <= 1'b0;
            end

            // A legal load on the wrap cycle bypasses the shadow entirely.
            if (div_load && w_legal) begin
                if (w_wrap) begin
                    r_d_act   <= div_in;
                    r_pending <= 1'b0;
                end else begin
                    r_shadow  <= div_in;
                    r_pending <= 1'b1;
                end
            end else if (w_wrap && r_pending) begin
                r_d_act   <= r_shadow;
                r_pending <= 1'b0;
            end
        end
    end

`ifdef CLK_DIV_ODD_DUTY50_EN
    logic r_q_neg;
    logic r_odd;

    // Parity is captured alongside q_pos so it tracks the period being generated.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_odd <= 1'b0;
        end else if (en) begin
            r_odd <= r_d_act[0];
        end
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            r_q_neg <= 1'b0;
        end else begin
            r_q_neg <= r_q_pos;
        end
    end

    assign clk_out = r_q_pos | (r_q_neg & r_odd);
`else
    assign clk_out = r_q_pos;
`endif

    assign tick    = r_tick;
    assign div_cur = r_d_act;
    assign pending = r_pending;
    assign div_err = r_div_err;

endmodule

`default_nettype wire
